// File: rtl/amm_simple_arbiter_if.sv
// Avalon-MM bus bundle. The arbiter's requester ports use the slave view.
// Its shared target port uses the master view.
interface avalon_mm_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, writedata, read, write,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, writedata, read, write,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/amm_simple_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter with round-robin grant and command locking.
// An ID FIFO of pending reads steers each readdatavalid back to the master that issued the read.
module amm_simple_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 4
) (
    input  logic        clk_i,
    input  logic        srst_i,
    avalon_mm_if.slave  master_if [1:0],
    avalon_mm_if.master slave_if,
    output logic        err_o
);
    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_PENDING);

    logic [1:0]        m_read, m_write, m_req, m_wait, m_rdv;
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];

    for (genvar i = 0; i < 2; i++) begin : g_master
        assign m_read[i]                  = master_if[i].read;
        assign m_write[i]                 = master_if[i].write;
        assign m_addr[i]                  = master_if[i].address;
        assign m_wdata[i]                 = master_if[i].writedata;
        assign master_if[i].waitrequest   = m_wait[i];
        assign master_if[i].readdatavalid = m_rdv[i];
        assign master_if[i].readdata      = slave_if.readdata;
    end

    assign m_req = m_read | m_write;

    logic                   lock_q, lock_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [MAX_PENDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;

    logic sel, full, s_read, s_write, accept, push, pop, head;

    // Grant selection: a stalled command keeps the grant; ties alternate.
    always_comb begin
        // NOTE: a default on entry covers every path, so no latch can be inferred.
        sel = owner_q;
        if (lock_q) begin
            sel = owner_q;
        end else if (m_req == 2'b01) begin
            sel = 1'b0;
        end else if (m_req == 2'b10) begin
            sel = 1'b1;
        end else if (m_req == 2'b11) begin
            sel = ~last_q;
        end
    end

    always_comb begin
        full    = (count_q == FULL_CNT);
        s_read  = ~srst_i & m_read[sel] & ~full;
        s_write = ~srst_i & m_write[sel];
        accept  = (s_read | s_write) & ~slave_if.waitrequest;
        push    = accept & s_read;
        pop     = slave_if.readdatavalid & (count_q != '0);
        head    = fifo_q[rd_ptr_q];

        m_wait = 2'b11;
        if (!srst_i) begin
            m_wait[sel] = slave_if.waitrequest | (m_read[sel] & full);
        end

        m_rdv = 2'b00;
        if (!srst_i && pop) begin
            m_rdv[head] = 1'b1;
        end
    end

    assign slave_if.address   = m_addr[sel];
    assign slave_if.writedata = m_wdata[sel];
    assign slave_if.read      = s_read;
    assign slave_if.write     = s_write;
    assign err_o              = err_q;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept) begin
            last_d = sel;
            lock_d = 1'b0;
        end else if (m_req[sel]) begin
            lock_d  = 1'b1;
            owner_d = sel;
        end else begin
            // The locked master dropped its request; release the grant.
            lock_d = 1'b0;
        end

        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        err_d    = err_q | (slave_if.readdatavalid & (count_q == '0));
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // NOTE: FIFO storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: doc/amm_simple_arbiter.md
AMM_SIMPLE_ARBITER -- requirements
Module: amm_simple_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning readdata/writedata width.
REQ-003 The block SHALL have parameter MAX_PENDING, default 4, meaning the maximum number of accepted reads still awaiting readdatavalid (power of two, >= 2).
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 srst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-006 master_if[1:0]  avalon_mm_if (slave side)  ADDR_W/DATA_W  two requesters; address, writedata, read and write are inputs; readdata, readdatavalid and waitrequest are outputs.
REQ-007 slave_if  avalon_mm_if (master side)  ADDR_W/DATA_W  shared target; address, writedata, read and write are outputs; readdata, readdatavalid and waitrequest are inputs.
REQ-008 err_o  output  1  sticky flag: readdatavalid arrived with no pending read recorded.

Function
REQ-009 The block SHALL combine two Avalon-MM masters onto one slave, acting as the counterpart of the 1-to-2 address demux.
REQ-010 Request of master i SHALL be req[i] = master_if[i].read | master_if[i].write.
REQ-011 State SHALL be held in registers: lock (1 b), owner (1 b), last (1 b, last master served), pending-ID FIFO (MAX_PENDING x 1 b) plus count (log2(MAX_PENDING)+1 b).
REQ-012 Selection sel (combinational): if lock, sel = owner; else if exactly one req, sel = that master; if both req, sel = !last (round-robin); if none, sel = owner.
REQ-013 slave_if.address and slave_if.writedata SHALL equal master_if[sel] fields, with no address translation.
REQ-014 slave_if.write SHALL equal master_if[sel].write.
REQ-015 slave_if.read SHALL equal master_if[sel].read & !full, where full = (count == MAX_PENDING).
REQ-016 master_if[sel].waitrequest SHALL equal slave_if.waitrequest | (master_if[sel].read & full).
REQ-017 master_if[!sel].waitrequest SHALL be 1.
REQ-018 accept = (slave_if.read | slave_if.write) & !slave_if.waitrequest; on accept, last <= sel and lock <= 0.
REQ-019 When a command is presented and not accepted (slave waitrequest, or read blocked by full), lock <= 1 and owner <= sel. The grant SHALL NOT switch until that command is accepted, even if the other master requests.
REQ-020 A locked master that drops its request without acceptance (protocol violation) SHALL clear lock on the next edge.
REQ-021 On an accepted read, sel SHALL be pushed into the pending-ID FIFO; an accepted write SHALL NOT push.
REQ-022 On slave_if.readdatavalid with count > 0, the FIFO head SHALL be popped. master_if[head].readdatavalid = 1 and master_if[!head].readdatavalid = 0 in that same cycle (zero-latency response path).
REQ-023 slave_if.readdata SHALL be routed to both master_if[i].readdata unconditionally.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; a read is blocked only when count == MAX_PENDING at cycle start, regardless of a same-cycle pop.
REQ-025 slave_if.readdatavalid with count == 0 SHALL set err_o, forward no readdatavalid to either master, and leave count at 0 (no underflow).
REQ-026 Simultaneous read and write from one master SHALL be passed through unchanged; the block SHALL NOT check for it.

Reset
REQ-027 While srst_i is high: lock=0, owner=0, last=1 (master 0 wins first tie), count=0, FIFO pointers=0, err_o=0.
REQ-028 While srst_i is high: slave_if.read/write=0, both master waitrequest=1, both master readdatavalid=0.
REQ-029 Reset asserted mid-transaction SHALL discard all pending IDs; responses arriving after reset release SHALL set err_o.

Verification
REQ-030 Both masters read same cycle after reset, slave waitrequest=0 -> M0 accepted cycle 0, M1 cycle 1; responses D0, D1 -> M0 gets D0, M1 gets D1 with readdatavalid only on the owner.
REQ-031 M1 write addr 0x0010, slave waitrequest high 3 cycles, M0 requests from cycle 1 -> slave sees M1 address stable 4 cycles; M0 granted the cycle after acceptance.
REQ-032 MAX_PENDING=4, M0 issues 5 back-to-back reads, no responses -> 5th read: slave_if.read=0, M0 waitrequest=1 until first readdatavalid, then accepted the next cycle.
REQ-033 Interleaved reads M0,M1,M1,M0 with responses returning later in order -> readdatavalid to M0,M1,M1,M0 exactly; count returns to 0.
REQ-034 readdatavalid pulse with nothing pending -> err_o=1 and stays 1; no master readdatavalid; srst_i clears err_o.
